alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Multi-cycle 8-bit ALU sitting directly downstream of the control unit's ALU states.
- The CU raises alu_executing (start) and waits for a rising edge on alu_done (done). This block implements that start/done handshake.
- Single-cycle ops: add/sub, logic, shift, inc/dec. Iterative ops: shift-add multiply and restoring divide.
- Result and status flags are held until the next completed operation.

Parameters:
- WIDTH, 8, operand/result width.
- ITERS, WIDTH, iteration count for MUL/DIV (one bit per cycle).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request from CU (alu_executing); may stay high up to 2 cycles
- op  input  4  operation, alu_op_t, sampled on accepted start
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- done  output  1  high when idle/complete, low while busy
- result  output  WIDTH  registered result of last completed op
- flag_z  output  1  result == 0
- flag_c  output  1  carry/borrow/shift-out (see Behaviour)
- flag_n  output  1  result MSB
- flag_v  output  1  signed overflow (ADD/ADC/SUB/SBC only, else 0)
- div_zero  output  1  last DIV/MOD had b == 0

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE, done=1, result=0, all flags=0, div_zero=0. An in-flight op is aborted with no partial writeback.
- Op encoding: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT A, 8 SHL, 9 SHR, 10 INC A, 11 DEC A, 12 MULLO, 13 MULHI, 14 DIV, 15 MOD.
- State machine states: IDLE, EXEC, ITER, FINISH.
- Accept rule: start is accepted only in IDLE. start while not IDLE is ignored; this covers the CU's second start cycle.
- Accept at edge T: latch op/a/b; done=0 from T+1.
- Single-cycle ops: IDLE -> EXEC -> IDLE. Result and flags are written and done=1 at T+2, so done is low exactly one cycle.
- MUL/DIV: IDLE -> ITER (ITERS cycles, counter 0..ITERS-1) -> FINISH -> IDLE. done=1 at T+ITERS+2 (T+10 for WIDTH=8).
- done rises only together with the result/flag update. The CU edge detector therefore always sees result valid in the cycle done=1.
- ADC/SBC use the held flag_c as carry-in. All other ops ignore it.
- SUB/SBC: flag_c=1 means borrow.
- SHL/SHR: flag_c = bit shifted out.
- INC/DEC: flag_c = carry/borrow out.
- AND/OR/XOR/NOT: flag_c=0, flag_v=0.
- MULLO/MULHI: full 2*WIDTH product; the selected half goes to result; flag_c = (high half != 0).
- DIV/MOD: unsigned restoring division; quotient or remainder goes to result.
- b == 0 on DIV/MOD: full ITER duration is still taken; quotient = all ones, remainder = a, div_zero=1, flag_c=1.
- div_zero is cleared by any other completed op.
- flag_z/flag_n always reflect the written result.
- Back-to-back: start high in the same cycle done returns to 1 is accepted (state is IDLE by then).

Decomposition:
- Shared package cpu_pkg holds:
  - alu_op_t enum (4-bit encodings above).
  - ALU state enum.
  - Flag bit index constants shared with the CU flag vector.
- One sub-module: alu_muldiv. It is the iterative shift-add multiplier / restoring divider, with a load/step interface and a product/quotient/remainder output, driven by the ITER counter in alu_seq.
- Combinational ops stay inline in alu_seq.

Test Plan:
- Reset then ADD a=0xFF b=0x01, start 1 cycle -> done 1,0,1 over T..T+2; result=0x00, Z=1, C=1, N=0, V=0.
- SUB a=0x05 b=0x07 -> result=0xFE, C=1 (borrow), N=1, Z=0. Then SBC a=0x10 b=0x00 -> result=0x0F.
- MULLO a=200 b=3 held start 2 cycles -> done low 9 cycles, result=0x58, C=1. MULHI same operands -> result=0x02. Second start cycle must not restart.
- DIV a=100 b=7 -> 14 (0x0E); MOD -> 2; DIV a=0x42 b=0 -> result=0xFF, div_zero=1, C=1; MOD a=0x42 b=0 -> 0x42.
- Assert rst_n low at iteration 4 of MULLO -> done=1, result=0 immediately. After release, ADD a=1 b=1 -> result=2, correct timing.
- Start held continuously across completions with op alternating INC/DEC from a=0x7F -> each result separated by exactly one done-low cycle; INC gives 0x80, N=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, ALU sequencer states
// and flag-vector bit positions used by the control unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBC   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_INC   = 4'd10,
    OP_DEC   = 4'd11,
    OP_MULLO = 4'd12,
    OP_MULHI = 4'd13,
    OP_DIV   = 4'd14,
    OP_MOD   = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_ITER,
    ST_FINISH
  } alu_state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

  function automatic logic is_iter_op(input alu_op_t o);
    return o inside {OP_MULLO, OP_MULHI, OP_DIV, OP_MOD};
  endfunction

  function automatic logic is_div_op(input alu_op_t o);
    return o inside {OP_DIV, OP_MOD};
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative datapath: shift-add multiply or restoring divide,
// one operand bit per step after a load.
module alu_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic             div_mode;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // One multiply add-and-shift or one divide trial-subtract.
  always_comb begin
    sum  = {1'b0, hi} + {1'b0, (lo[0] ? m : '0)};
    t    = {hi, lo[WIDTH-1]};
    ge   = (t >= {1'b0, m});
    diff = t[WIDTH-1:0] - m;
  end

  // hi/lo hold product halves, or remainder/quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      div_mode <= is_div;
      m        <= is_div ? b : a;
      lo       <= is_div ? a : b;
      hi       <= '0;
    end else if (step) begin
      if (div_mode) begin
        hi <= ge ? diff : t[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], ge};
      end else begin
        hi <= sum[WIDTH:1];
        lo <= {sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign product   = {hi, lo};
  assign quotient  = lo;
  assign remainder = hi;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU behind the CU start/done handshake;
// single-cycle ops inline, MUL/DIV via alu_muldiv.
import cpu_pkg::*;

module alu_seq #(
  parameter int WIDTH = 8,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             div_zero
);

  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam int MSB = WIDTH - 1;

  alu_state_t       state;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;

  logic               accept;
  logic               wb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   cin;
  logic [WIDTH-1:0] wr_res;
  logic             wr_c;
  logic             wr_v;
  logic             wr_dz;

  assign accept = (state == ST_IDLE) && start;
  assign wb     = (state == ST_EXEC) || (state == ST_FINISH);
  assign cin    = {{WIDTH{1'b0}}, flag_c};

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (state == ST_ITER),
    .is_div    (is_div_op(op)),
    .a         (a),
    .b         (b),
    .product   (prod),
    .quotient  (quot),
    .remainder (rem)
  );

  // Writeback value and flags for the latched op.
  always_comb begin
    ext    = '0;
    wr_res = '0;
    wr_c   = 1'b0;
    wr_v   = 1'b0;
    wr_dz  = 1'b0;
    unique case (op_q)
      OP_ADD, OP_ADC: begin
        ext    = {1'b0, a_q} + {1'b0, b_q}
               + ((op_q == OP_ADC) ? cin : '0);
        wr_res = ext[MSB:0];
        wr_c   = ext[WIDTH];
        wr_v   = (a_q[MSB] == b_q[MSB])
               && (ext[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_SBC: begin
        ext    = {1'b0, a_q} - {1'b0, b_q}
               - ((op_q == OP_SBC) ? cin : '0);
        wr_res = ext[MSB:0];
        wr_c   = ext[WIDTH];
        wr_v   = (a_q[MSB] != b_q[MSB])
               && (ext[MSB] != a_q[MSB]);
      end
      OP_AND: wr_res = a_q & b_q;
      OP_OR:  wr_res = a_q | b_q;
      OP_XOR: wr_res = a_q ^ b_q;
      OP_NOT: wr_res = ~a_q;
      OP_SHL: begin
        wr_res = {a_q[MSB-1:0], 1'b0};
        wr_c   = a_q[MSB];
      end
      OP_SHR: begin
        wr_res = {1'b0, a_q[MSB:1]};
        wr_c   = a_q[0];
      end
      OP_INC: begin
        ext    = {1'b0, a_q} + ONE;
        wr_res = ext[MSB:0];
        wr_c   = ext[WIDTH];
      end
      OP_DEC: begin
        ext    = {1'b0, a_q} - ONE;
        wr_res = ext[MSB:0];
        wr_c   = ext[WIDTH];
      end
      OP_MULLO, OP_MULHI: begin
        wr_res = (op_q == OP_MULLO) ? prod[WIDTH-1:0]
                                    : prod[2*WIDTH-1:WIDTH];
        wr_c   = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV, OP_MOD: begin
        wr_res = (op_q == OP_DIV) ? quot : rem;
        wr_dz  = (b_q == '0);
        wr_c   = wr_dz;
      end
      default: ;
    endcase
  end

  // Sequencer plus registered result/flags; done rises with writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      done     <= 1'b1;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_n   <= 1'b0;
      flag_v   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            done  <= 1'b0;
            state <= is_iter_op(op) ? ST_ITER : ST_EXEC;
          end
        end
        ST_ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= ST_FINISH;
        end
        ST_EXEC, ST_FINISH: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (wb) begin
        result   <= wr_res;
        flag_z   <= (wr_res == '0);
        flag_n   <= wr_res[MSB];
        flag_c   <= wr_c;
        flag_v   <= wr_v;
        div_zero <= wr_dz;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random bench for alu_seq against an
// integer-arithmetic reference model.
import cpu_pkg::*;

module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  alu_op_t    op = OP_ADD;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       done;
  logic [7:0] result;
  logic       flag_z, flag_c, flag_n, flag_v, div_zero;

  int checks = 0;
  int errors = 0;

  int m_res, m_z, m_c, m_n, m_v, m_dz;

  alu_seq #(.WIDTH(8), .ITERS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .done     (done),
    .result   (result),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_n   (flag_n),
    .flag_v   (flag_v),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_reset();
    m_res = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_dz = 0;
  endtask

  task automatic model(input alu_op_t o, input int x, input int y);
    int s, sv, ci, r, c, v, dz;
    c = 0; v = 0; dz = 0; r = 0;
    ci = (o == OP_ADC || o == OP_SBC) ? m_c : 0;
    case (o)
      OP_ADD, OP_ADC: begin
        s = x + y + ci; r = s % 256; c = (s > 255);
        sv = sgn(x) + sgn(y) + ci; v = (sv > 127 || sv < -128);
      end
      OP_SUB, OP_SBC: begin
        s = x - y - ci; r = (s + 512) % 256; c = (s < 0);
        sv = sgn(x) - sgn(y) - ci; v = (sv > 127 || sv < -128);
      end
      OP_AND: for (int i = 0, p = 1; i < 8; i++, p *= 2)
                if ((x / p) % 2 == 1 && (y / p) % 2 == 1) r += p;
      OP_OR:  for (int i = 0, p = 1; i < 8; i++, p *= 2)
                if ((x / p) % 2 == 1 || (y / p) % 2 == 1) r += p;
      OP_XOR: for (int i = 0, p = 1; i < 8; i++, p *= 2)
                if ((x / p) % 2 != (y / p) % 2) r += p;
      OP_NOT: r = 255 - x;
      OP_SHL: begin r = (x * 2) % 256; c = (x >= 128); end
      OP_SHR: begin r = x / 2; c = x % 2; end
      OP_INC: begin r = (x + 1) % 256; c = (x == 255); end
      OP_DEC: begin r = (x + 255) % 256; c = (x == 0); end
      OP_MULLO, OP_MULHI: begin
        s = x * y;
        r = (o == OP_MULLO) ? s % 256 : s / 256;
        c = (s >= 256);
      end
      default: begin
        if (y == 0) begin
          r = (o == OP_DIV) ? 255 : x; c = 1; dz = 1;
        end else begin
          r = (o == OP_DIV) ? x / y : x % y;
        end
      end
    endcase
    m_res = r; m_c = c; m_v = v; m_dz = dz;
    m_z = (r == 0); m_n = (r >= 128);
  endtask

  task automatic chk_out(input string t);
    chk({t, "_res"}, 32'(result), 32'(m_res));
    chk({t, "_z"}, 32'(flag_z), 32'(m_z));
    chk({t, "_c"}, 32'(flag_c), 32'(m_c));
    chk({t, "_n"}, 32'(flag_n), 32'(m_n));
    chk({t, "_v"}, 32'(flag_v), 32'(m_v));
    chk({t, "_dz"}, 32'(div_zero), 32'(m_dz));
  endtask

  task automatic run_op(input string t, input alu_op_t o,
                        input logic [7:0] x, input logic [7:0] y,
                        input int hold);
    int n;
    int lat;
    lat = (o inside {OP_MULLO, OP_MULHI, OP_DIV, OP_MOD}) ? 9 : 1;
    @(negedge clk);
    chk({t, "_idle"}, 32'(done), 1);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    chk({t, "_busy"}, 32'(done), 0);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (n + 1 >= hold) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done === 1'b1 || n > 30) break;
    end
    start = 1'b0;
    chk({t, "_lat"}, 32'(n), 32'(lat));
    model(o, int'(x), int'(y));
    chk_out(t);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 1);
    chk_out("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ff", OP_ADD, 8'hFF, 8'h01, 1);
    run_op("sub", OP_SUB, 8'h05, 8'h07, 1);
    run_op("sbc", OP_SBC, 8'h10, 8'h00, 1);
    run_op("mullo", OP_MULLO, 8'd200, 8'd3, 2);
    run_op("mulhi", OP_MULHI, 8'd200, 8'd3, 2);
    run_op("div", OP_DIV, 8'd100, 8'd7, 1);
    run_op("mod", OP_MOD, 8'd100, 8'd7, 1);
    run_op("div0", OP_DIV, 8'h42, 8'h00, 1);
    run_op("mod0", OP_MOD, 8'h42, 8'h00, 2);
    run_op("adc", OP_ADC, 8'h7F, 8'h00, 1);

    // Reset asserted mid-multiply aborts without writeback.
    @(negedge clk);
    op = OP_MULLO; a = 8'd200; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_done", 32'(done), 1);
    chk_out("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add11", OP_ADD, 8'h01, 8'h01, 1);

    // Start held high: INC/DEC back to back.
    @(negedge clk);
    op = OP_INC; a = 8'h7F; b = 8'h00; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("b2b_busy", 32'(done), 0);
      model(op, 32'h7F, 0);
      @(posedge clk); #1;
      chk("b2b_done", 32'(done), 1);
      chk_out((k % 2 == 0) ? "b2b_inc" : "b2b_dec");
      if (k == 5) start = 1'b0;
      else op = (k % 2 == 0) ? OP_DEC : OP_INC;
    end

    for (int i = 0; i < 40; i++) begin
      run_op("rnd", alu_op_t'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)),
             8'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255)),
             int'($urandom_range(1, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
